// File: rtl/qam_axi_write_sched.sv
// qam_axi_write_sched: buffers combined I/Q samples in a small FIFO and writes them one
// at a time to a circular SRAM window over AXI4-Lite. Optional one-shot fill: QAM_WSCHED_ONESHOT_EN.
module qam_axi_write_sched #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int unsigned       DEPTH_WORDS = 1024,
   parameter int unsigned       FIFO_DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic [ADDR_W-1:0] M_AXI_AWADDR,
   output logic [2:0]        M_AXI_AWPROT,
   output logic              M_AXI_AWVALID,
   input  logic              M_AXI_AWREADY,
   output logic [DATA_W-1:0] M_AXI_WDATA,
   output logic [3:0]        M_AXI_WSTRB,
   output logic              M_AXI_WVALID,
   input  logic              M_AXI_WREADY,
   input  logic [1:0]        M_AXI_BRESP,
   input  logic              M_AXI_BVALID,
   output logic              M_AXI_BREADY,
   output logic [31:0]       wr_count,
   output logic              wrap_pulse,
   output logic              overflow,
   output logic              resp_err,
   output logic              busy
);

   localparam int unsigned   PW       = $clog2(DEPTH_WORDS);
   localparam int unsigned   FW       = $clog2(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_RESP
`ifdef QAM_WSCHED_ONESHOT_EN
      , S_DONE
`endif
   } state_t;

   state_t              state_q, state_d;
   logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [31:0]         count_q, count_d;
   logic                err_q, err_d, wrap_q, wrap_d, ovf_q;
   logic                flush;
`ifdef QAM_WSCHED_ONESHOT_EN
   logic                seen_low_q, seen_low_d;
`endif

   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [FW:0]         wr_idx, rd_idx;
   logic                fifo_empty, fifo_full, accepting, push_req, push, pop, drop;

   assign fifo_empty = (wr_idx == rd_idx);
   assign fifo_full  = (wr_idx[FW] != rd_idx[FW]) && (wr_idx[FW-1:0] == rd_idx[FW-1:0]);

`ifdef QAM_WSCHED_ONESHOT_EN
   assign accepting = enable && (state_q != S_DONE);
`else
   assign accepting = enable;
`endif
   assign push_req = s_valid && accepting;
   assign pop      = (state_q == S_IDLE) && enable && !fifo_empty;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign push     = push_req && (!fifo_full || pop);
   assign drop     = push_req && fifo_full && !pop;

   // NOTE: the sample store has no reset; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_idx[FW-1:0]] <= s_data;
   end

   // NOTE: every output written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      err_d     = err_q;
      wrap_d    = 1'b0;
      flush     = 1'b0;
`ifdef QAM_WSCHED_ONESHOT_EN
      seen_low_d = seen_low_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (pop) begin
               wdata_d   = fifo_mem[rd_idx[FW-1:0]];
               awaddr_d  = BASE_ADDR + ADDR_W'({ptr_q, 2'b00});
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            // Address and data channels retire independently, in either order.
            awvalid_d = awvalid_q && !M_AXI_AWREADY;
            wvalid_d  = wvalid_q && !M_AXI_WREADY;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (M_AXI_BVALID && bready_q) begin
               bready_d = 1'b0;
               if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
               if (M_AXI_BRESP != 2'b00) err_d = 1'b1;
               ptr_d   = ptr_q + 1'b1;
               wrap_d  = (ptr_q == LAST_PTR);
               state_d = S_IDLE;
`ifdef QAM_WSCHED_ONESHOT_EN
               if (ptr_q == LAST_PTR) begin
                  state_d    = S_DONE;
                  seen_low_d = 1'b0;
               end
`endif
            end
         end
`ifdef QAM_WSCHED_ONESHOT_EN
         S_DONE: begin
            // Restart needs a full enable 1->0->1 sequence after the window fills.
            if (!enable) begin
               seen_low_d = 1'b1;
            end else if (seen_low_q) begin
               seen_low_d = 1'b0;
               ptr_d      = '0;
               flush      = 1'b1;
               state_d    = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         awaddr_q  <= BASE_ADDR;
         wdata_q   <= '0;
         ptr_q     <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
         wrap_q    <= 1'b0;
         ovf_q     <= 1'b0;
         wr_idx    <= '0;
         rd_idx    <= '0;
`ifdef QAM_WSCHED_ONESHOT_EN
         seen_low_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         err_q     <= err_d;
         wrap_q    <= wrap_d;
         if (drop) ovf_q <= 1'b1;
         if (flush) begin
            wr_idx <= '0;
            rd_idx <= '0;
         end else begin
            if (push) wr_idx <= wr_idx + 1'b1;
            if (pop)  rd_idx <= rd_idx + 1'b1;
         end
`ifdef QAM_WSCHED_ONESHOT_EN
         seen_low_q <= seen_low_d;
`endif
      end
   end

   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign wr_count      = count_q;
   assign wrap_pulse    = wrap_q;
   assign overflow      = ovf_q;
   assign resp_err      = err_q;
   assign busy          = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_qam_axi_write_sched.sv
// Scoreboard bench for qam_axi_write_sched: directed samples push expected writes into a
// queue; a monitor pops and compares on each completed AW+W pair, with a stalling AXI slave.
module tb_qam_axi_write_sched;

   logic        clk = 1'b0;
   logic        reset, enable, s_valid;
   logic [31:0] s_data;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, wr_count;
   logic [2:0]  M_AXI_AWPROT;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY;
   logic        wrap_pulse, overflow, resp_err, busy;

   always #5 clk = ~clk;

   qam_axi_write_sched #(
      .ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h0000_1000), .DEPTH_WORDS(4), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid), .s_data(s_data),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
      .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
      .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .wr_count(wr_count),
      .wrap_pulse(wrap_pulse), .overflow(overflow), .resp_err(resp_err), .busy(busy)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        wrap;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   aw_stall = 0, w_stall = 0, b_stall = 0;
   int   nb = 0, err_write = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", name, act, want, $time);
      end
   endtask

   task automatic push_sample(input logic [31:0] d);
      s_valid = 1'b1;
      s_data  = d;
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic issue(input logic [31:0] d, input logic [31:0] addr, input logic wrap);
      exp_t e;
      e.addr = addr;
      e.data = d;
      e.wrap = wrap;
      exp_q.push_back(e);
      push_sample(d);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while ((busy || exp_q.size() != 0) && n < 1000);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // AXI slave with programmable AW/W/B stalls; decisions are taken 1 time unit after each edge.
   initial begin : slave
      bit aw_hs, w_hs, b_hs, aw_got, w_got;
      int aw_cnt, w_cnt, b_cnt;
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
      aw_hs = 0; w_hs = 0; b_hs = 0; aw_got = 0; w_got = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      forever begin
         @(posedge clk); #1;
         if (!reset) begin
            M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
            aw_hs = 0; w_hs = 0; b_hs = 0; aw_got = 0; w_got = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            continue;
         end
         if (aw_hs) begin aw_got = 1; aw_cnt = 0; end
         if (w_hs)  begin w_got = 1;  w_cnt = 0;  end
         if (b_hs)  begin aw_got = 0; w_got = 0; b_cnt = 0; nb++; end
         M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_stall);
         if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_cnt++;
         M_AXI_WREADY = M_AXI_WVALID && (w_cnt >= w_stall);
         if (M_AXI_WVALID && !M_AXI_WREADY) w_cnt++;
         M_AXI_BVALID = aw_got && w_got && (b_cnt >= b_stall);
         if (aw_got && w_got && !M_AXI_BVALID) b_cnt++;
         M_AXI_BRESP = (M_AXI_BVALID && nb == err_write) ? 2'b10 : 2'b00;
         aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
         w_hs  = M_AXI_WVALID && M_AXI_WREADY;
         b_hs  = M_AXI_BVALID && M_AXI_BREADY;
      end
   end

   // Monitor: pairs AW/W handshakes, checks against the queue, channel stability and wrap timing.
   initial begin : monitor
      bit          aw_seen, w_seen, aw_wait, w_wait, b_prev, b_wrap;
      logic [31:0] cap_addr, cap_data, prev_addr, prev_data;
      exp_t        e;
      aw_seen = 0; w_seen = 0; aw_wait = 0; w_wait = 0; b_prev = 0; b_wrap = 0;
      cap_addr = '0; cap_data = '0; prev_addr = '0; prev_data = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            aw_seen = 0; w_seen = 0; aw_wait = 0; w_wait = 0; b_prev = 0;
            continue;
         end
         if (aw_wait) begin
            check("awvalid_hold", 32'(M_AXI_AWVALID), 32'd1);
            check("awaddr_hold", M_AXI_AWADDR, prev_addr);
         end
         if (w_wait) begin
            check("wvalid_hold", 32'(M_AXI_WVALID), 32'd1);
            check("wdata_hold", M_AXI_WDATA, prev_data);
         end
         check("wrap_pulse", 32'(wrap_pulse), 32'(b_prev ? b_wrap : 1'b0));
         b_prev = M_AXI_BVALID && M_AXI_BREADY;
         if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_seen = 1; cap_addr = M_AXI_AWADDR; end
         if (M_AXI_WVALID && M_AXI_WREADY)   begin w_seen = 1;  cap_data = M_AXI_WDATA;  end
         if (aw_seen && w_seen) begin
            if (exp_q.size() == 0) begin
               check("write_expected", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("awaddr", cap_addr, e.addr);
               check("wdata", cap_data, e.data);
               b_wrap = e.wrap;
            end
            aw_seen = 0;
            w_seen  = 0;
         end
         aw_wait   = M_AXI_AWVALID && !M_AXI_AWREADY;
         w_wait    = M_AXI_WVALID && !M_AXI_WREADY;
         prev_addr = M_AXI_AWADDR;
         prev_data = M_AXI_WDATA;
      end
   end

   initial begin : main
      int n;
      reset = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_awvalid", 32'(M_AXI_AWVALID), 32'd0);
      check("rst_wvalid", 32'(M_AXI_WVALID), 32'd0);
      check("rst_bready", 32'(M_AXI_BREADY), 32'd0);
      check("rst_wr_count", wr_count, 32'd0);
      check("rst_flags", {28'd0, wrap_pulse, overflow, resp_err, busy}, 32'd0);
      check("awprot_wstrb", {25'd0, M_AXI_AWPROT, M_AXI_WSTRB}, 32'h0000_000F);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      enable = 1'b1;

      // Four samples, zero-wait slave; the 4th hits the last window word.
      issue(32'hA5A5_0001, 32'h0000_1000, 1'b0);
      issue(32'hA5A5_0002, 32'h0000_1004, 1'b0);
      issue(32'hA5A5_0003, 32'h0000_1008, 1'b0);
      issue(32'hA5A5_0004, 32'h0000_100C, 1'b1);
      wait_idle("t1");
      check("t1_wr_count", wr_count, 32'd4);
      check("t1_overflow", 32'(overflow), 32'd0);
      check("t1_resp_err", 32'(resp_err), 32'd0);

      // Fifth write wraps back to the base address.
      issue(32'hA5A5_0005, 32'h0000_1000, 1'b0);
      wait_idle("t2");
      check("t2_wr_count", wr_count, 32'd5);

      // AWREADY held low for 5 cycles, WREADY immediate.
      aw_stall = 5;
      issue(32'hB000_0001, 32'h0000_1004, 1'b0);
      n = 0;
      @(negedge clk);
      while (!M_AXI_AWVALID && n < 20) begin @(negedge clk); n++; end
      check("t3_wvalid_first", 32'(M_AXI_WVALID), 32'd1);
      n = 0;
      while (M_AXI_AWVALID && n < 20) begin
         if (n == 1) check("t3_wvalid_drop", 32'(M_AXI_WVALID), 32'd0);
         n++;
         @(negedge clk);
      end
      check("t3_aw_cycles", 32'(n), 32'd6);
      aw_stall = 0;
      wait_idle("t3");
      check("t3_wr_count", wr_count, 32'd6);

      // BVALID stalled while 12 samples arrive: 8 kept, 4 dropped.
      b_stall = 20;
      issue(32'hC000_0000, 32'h0000_1008, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      issue(32'hC000_0001, 32'h0000_100C, 1'b1);
      issue(32'hC000_0002, 32'h0000_1000, 1'b0);
      issue(32'hC000_0003, 32'h0000_1004, 1'b0);
      issue(32'hC000_0004, 32'h0000_1008, 1'b0);
      issue(32'hC000_0005, 32'h0000_100C, 1'b1);
      issue(32'hC000_0006, 32'h0000_1000, 1'b0);
      issue(32'hC000_0007, 32'h0000_1004, 1'b0);
      issue(32'hC000_0008, 32'h0000_1008, 1'b0);
      for (int i = 9; i <= 12; i++) push_sample(32'hC000_0000 + 32'(i));
      check("t4_overflow", 32'(overflow), 32'd1);
      wait_idle("t4");
      check("t4_wr_count", wr_count, 32'd15);

      // enable dropped mid-transaction: current write completes, queued sample is held.
      b_stall = 10;
      issue(32'h6000_0001, 32'h0000_100C, 1'b1);
      issue(32'h6000_0002, 32'h0000_1000, 1'b0);
      n = 0;
      @(negedge clk);
      while (!M_AXI_BREADY && n < 50) begin @(negedge clk); n++; end
      enable = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("t5_wr_count_hold", wr_count, 32'd16);
      check("t5_busy_retained", 32'(busy), 32'd1);
      check("t5_no_new_aw", 32'(M_AXI_AWVALID), 32'd0);
      enable  = 1'b1;
      b_stall = 0;
      wait_idle("t5");
      check("t5_wr_count", wr_count, 32'd17);

      // Reset asserted while the address phase is stalled.
      aw_stall = 3;
      push_sample(32'hE000_0001);
      n = 0;
      @(negedge clk);
      while (!M_AXI_AWVALID && n < 20) begin @(negedge clk); n++; end
      #2 reset = 1'b0;
      #1;
      check("t6_awvalid", 32'(M_AXI_AWVALID), 32'd0);
      check("t6_wvalid", 32'(M_AXI_WVALID), 32'd0);
      check("t6_bready", 32'(M_AXI_BREADY), 32'd0);
      check("t6_wr_count", wr_count, 32'd0);
      check("t6_sticky_clear", {30'd0, overflow, resp_err}, 32'd0);
      aw_stall = 0;
      exp_q.delete();
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;

      // Samples with enable=0 are ignored and cannot overflow.
      enable = 1'b0;
      for (int i = 0; i < 10; i++) push_sample(32'hEE00_0000 + 32'(i));
      repeat (4) @(posedge clk);
      #1;
      check("t7_overflow", 32'(overflow), 32'd0);
      check("t7_busy", 32'(busy), 32'd0);
      enable = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("t7_busy_after_en", 32'(busy), 32'd0);
      check("t7_wr_count", wr_count, 32'd0);

      // Fill the FIFO, then push in the very cycle the head is popped: no overflow.
      b_stall = 20;
      issue(32'hD000_0000, 32'h0000_1000, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      issue(32'hD000_0001, 32'h0000_1004, 1'b0);
      issue(32'hD000_0002, 32'h0000_1008, 1'b0);
      issue(32'hD000_0003, 32'h0000_100C, 1'b1);
      issue(32'hD000_0004, 32'h0000_1000, 1'b0);
      issue(32'hD000_0005, 32'h0000_1004, 1'b0);
      issue(32'hD000_0006, 32'h0000_1008, 1'b0);
      issue(32'hD000_0007, 32'h0000_100C, 1'b1);
      issue(32'hD000_0008, 32'h0000_1000, 1'b0);
      n = 0;
      @(negedge clk);
      while (!(M_AXI_BVALID && M_AXI_BREADY) && n < 100) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      issue(32'hD000_0009, 32'h0000_1004, 1'b0);
      wait_idle("t8");
      check("t8_overflow", 32'(overflow), 32'd0);
      check("t8_wr_count", wr_count, 32'd10);
      b_stall = 0;

      // SLVERR on the second of three writes; pointer still advances, flag is sticky.
      err_write = nb + 1;
      issue(32'hF000_0001, 32'h0000_1008, 1'b0);
      issue(32'hF000_0002, 32'h0000_100C, 1'b1);
      issue(32'hF000_0003, 32'h0000_1000, 1'b0);
      wait_idle("t9");
      check("t9_resp_err", 32'(resp_err), 32'd1);
      check("t9_wr_count", wr_count, 32'd13);
      err_write = -1;
      issue(32'hF000_0004, 32'h0000_1004, 1'b0);
      wait_idle("t9b");
      check("t9_resp_err_sticky", 32'(resp_err), 32'd1);
      check("t9_wr_count_b", wr_count, 32'd14);

      check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
